pd_dw_nr_pwr_acc: RTL and testbench

//  Per-symbol power accumulator for downlink NR power detection. Squares each valid IQ sample (I^2+Q^2) and integrates over one OFDM symbol.
//  At each symbol boundary it emits one write (we/addr/din) addressed by symbol index within the frame.

---
 rtl/pd_dw_nr_pwr_acc.sv | 180 ++++++++++++++++++
 tb/tb_pd_dw_nr_pwr_acc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_dw_nr_pwr_acc.sv
// Per-symbol IQ power accumulator: squares each valid sample, integrates over an
// OFDM symbol and emits one bus write per symbol, addressed by symbol index in the frame.
//
// state | meaning
// IDLE  | disabled or waiting for the first frame head; samples dropped, nothing emitted
// RUN   | integrating the current symbol; each head emits the finished symbol
module pd_dw_nr_pwr_acc #(
  parameter int IQ_W    = 16,
  parameter int ACC_W   = 48,
  parameter int SYM_NUM = 1120,
  parameter int ADDR_W  = 11
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic                   i_frame_head,
  input  logic                   i_sym_head,
  input  logic signed [IQ_W-1:0] i_data_i,
  input  logic signed [IQ_W-1:0] i_data_q,
  output logic                   o_we,
  output logic [ADDR_W-1:0]      o_addr,
  output logic [ACC_W-1:0]       o_din,
  output logic                   o_ovf,
  output logic                   o_frm_err
);

  localparam int SQ_W = 2 * IQ_W;
  localparam int P_W  = SQ_W + 1;
  localparam logic [ADDR_W-1:0] LAST_SYM = ADDR_W'(SYM_NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic                   s1_en, s1_vld, s1_fh, s1_sh;
  logic signed [IQ_W-1:0] s1_i, s1_q;
  logic signed [SQ_W-1:0] s1_i_x, s1_q_x;

  logic                   s2_vld, s2_fh, s2_sh;
  logic signed [SQ_W-1:0] s2_sqi, s2_sqq;

  logic                   s3_vld, s3_fh, s3_sh;
  logic [P_W-1:0]         s3_p;

  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ADDR_W-1:0] sym_cnt, cnt_nxt;
  logic [ACC_W:0]    p_ext, sum;
  logic              we_nxt, ovf_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ACC_W-1:0]  din_nxt;

  assign s1_i_x = SQ_W'(s1_i);
  assign s1_q_x = SQ_W'(s1_q);

  // Heads are qualified by valid and enable at the input so later stages only see real heads.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      s1_en  <= 1'b0;
      s1_vld <= 1'b0;
      s1_fh  <= 1'b0;
      s1_sh  <= 1'b0;
      s1_i   <= '0;
      s1_q   <= '0;
    end else begin
      s1_en  <= i_en;
      s1_vld <= i_valid & i_en;
      s1_fh  <= i_valid & i_en & i_frame_head;
      s1_sh  <= i_valid & i_en & i_sym_head;
      s1_i   <= i_data_i;
      s1_q   <= i_data_q;
    end
  end

  // A low registered enable flushes everything already in S2/S3.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      s2_vld <= 1'b0;
      s2_fh  <= 1'b0;
      s2_sh  <= 1'b0;
      s2_sqi <= '0;
      s2_sqq <= '0;
      s3_vld <= 1'b0;
      s3_fh  <= 1'b0;
      s3_sh  <= 1'b0;
      s3_p   <= '0;
    end else begin
      s2_vld <= s1_vld & s1_en;
      s2_fh  <= s1_fh & s1_en;
      s2_sh  <= s1_sh & s1_en;
      s2_sqi <= s1_i_x * s1_i_x;
      s2_sqq <= s1_q_x * s1_q_x;
      s3_vld <= s2_vld & s1_en;
      s3_fh  <= s2_fh & s1_en;
      s3_sh  <= s2_sh & s1_en;
      s3_p   <= {1'b0, s2_sqi} + {1'b0, s2_sqq};
    end
  end

  assign p_ext = {{(ACC_W + 1 - P_W){1'b0}}, s3_p};
  assign sum   = {1'b0, acc} + p_ext;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = sym_cnt;
    we_nxt    = 1'b0;
    addr_nxt  = o_addr;
    din_nxt   = o_din;
    ovf_nxt   = o_ovf;
    err_nxt   = o_frm_err;
    if (!s1_en) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s3_vld && s3_fh) begin
            state_nxt = RUN;
            acc_nxt   = p_ext[ACC_W-1:0];
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (s3_vld) begin
            if (s3_fh || s3_sh) begin
              we_nxt   = 1'b1;
              addr_nxt = sym_cnt;
              din_nxt  = acc;
              acc_nxt  = p_ext[ACC_W-1:0];
            end
            if (s3_fh) begin
              cnt_nxt = '0;
            end else if (s3_sh) begin
              if (sym_cnt == LAST_SYM) begin
                cnt_nxt = '0;
                err_nxt = 1'b1;
              end else begin
                cnt_nxt = sym_cnt + ADDR_W'(1);
              end
            end else if (sum[ACC_W]) begin
              acc_nxt = '1;
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt = sum[ACC_W-1:0];
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      acc       <= '0;
      sym_cnt   <= '0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_din     <= '0;
      o_ovf     <= 1'b0;
      o_frm_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      sym_cnt   <= cnt_nxt;
      o_we      <= we_nxt;
      o_addr    <= addr_nxt;
      o_din     <= din_nxt;
      o_ovf     <= ovf_nxt;
      o_frm_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pd_dw_nr_pwr_acc.sv
// Directed bench for pd_dw_nr_pwr_acc: a default instance (a) and a small-frame,
// narrow-accumulator instance (b) share the same stimulus.
module tb_pd_dw_nr_pwr_acc;

  logic               sys_clk = 1'b0;
  logic               sys_rst, i_en, i_valid, i_frame_head, i_sym_head;
  logic signed [15:0] i_data_i, i_data_q;

  logic        a_we, a_ovf, a_err;
  logic [10:0] a_addr;
  logic [47:0] a_din;
  logic        b_we, b_ovf, b_err;
  logic [10:0] b_addr;
  logic [39:0] b_din;

  pd_dw_nr_pwr_acc dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_en(i_en), .i_valid(i_valid),
    .i_frame_head(i_frame_head), .i_sym_head(i_sym_head),
    .i_data_i(i_data_i), .i_data_q(i_data_q),
    .o_we(a_we), .o_addr(a_addr), .o_din(a_din), .o_ovf(a_ovf), .o_frm_err(a_err)
  );

  pd_dw_nr_pwr_acc #(.SYM_NUM(4), .ACC_W(40)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_en(i_en), .i_valid(i_valid),
    .i_frame_head(i_frame_head), .i_sym_head(i_sym_head),
    .i_data_i(i_data_i), .i_data_q(i_data_q),
    .o_we(b_we), .o_addr(b_addr), .o_din(b_din), .o_ovf(b_ovf), .o_frm_err(b_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [10:0] addr;
    logic [47:0] din;
    int          cyc;
  } wr_t;

  typedef struct {
    logic signed [15:0] di;
    logic signed [15:0] dq;
    int                 n;
    logic [47:0]        exp_din;
  } vec_t;

  wr_t  qa[$];
  wr_t  qb[$];
  vec_t tbl[7];
  int   cyc = 0;
  int   head_edge;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (a_we) qa.push_back('{addr: a_addr, din: a_din, cyc: cyc});
    if (b_we) qb.push_back('{addr: b_addr, din: {8'h00, b_din}, cyc: cyc});
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_wr(input string nm, input bit use_b, input int addr,
                          input logic [47:0] din, output int wcyc);
    wr_t w;
    bit  empty;
    wcyc  = -1;
    empty = use_b ? (qb.size() == 0) : (qa.size() == 0);
    n_cmp++;
    if (empty) begin
      n_err++;
      $display("FAIL %s: no write seen, expected addr %0d din %0d", nm, addr, din);
    end else begin
      if (use_b) w = qb.pop_front();
      else       w = qa.pop_front();
      wcyc = w.cyc;
      check({nm, " addr"}, 64'(w.addr), 64'(addr));
      check({nm, " din"},  64'(w.din),  64'(din));
    end
  endtask

  task automatic check_none(input string nm);
    check({nm, " extra writes a"}, 64'(qa.size()), 64'd0);
    check({nm, " extra writes b"}, 64'(qb.size()), 64'd0);
  endtask

  task automatic symbol(input logic fh, input logic sh, input logic signed [15:0] di,
                        input logic signed [15:0] dq, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      i_valid      = 1'b1;
      i_frame_head = fh & (k == 0);
      i_sym_head   = sh & (k == 0);
      i_data_i     = di;
      i_data_q     = dq;
      if (k == 0) head_edge = cyc + 1;
    end
  endtask

  // Valid samples interleaved with invalid ones carrying large data and both heads.
  task automatic symbol_sparse(input logic fh, input logic sh, input logic signed [15:0] di,
                               input logic signed [15:0] dq, input int n);
    for (int k = 0; k < n; k++) begin
      symbol(fh & (k == 0), sh & (k == 0), di, dq, 1);
      @(negedge sys_clk);
      i_valid      = 1'b0;
      i_frame_head = 1'b1;
      i_sym_head   = 1'b1;
      i_data_i     = 16'sd20000;
      i_data_q     = 16'sd20000;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      i_valid      = 1'b0;
      i_frame_head = 1'b0;
      i_sym_head   = 1'b0;
      i_data_i     = '0;
      i_data_q     = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    i_en    = 1'b0;
    idle(2);
    sys_rst = 1'b1;
    i_en    = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int c0, c1, c2, h1, h2, h3;

    tbl[0] = '{16'sd1000,   16'sd0,      8, 48'd8000000};
    tbl[1] = '{16'sd3,      16'sd4,      2, 48'd50};
    tbl[2] = '{-16'sd32768, -16'sd32768, 3, 48'd6442450944};
    tbl[3] = '{-16'sd1,     16'sd1,      5, 48'd10};
    tbl[4] = '{16'sd0,      16'sd0,      4, 48'd0};
    tbl[5] = '{16'sd32767,  -16'sd32768, 1, 48'd2147418113};
    tbl[6] = '{-16'sd20000, 16'sd15000,  7, 48'd4375000000};

    sys_rst = 1'b0; i_en = 1'b0; i_valid = 1'b0;
    i_frame_head = 1'b0; i_sym_head = 1'b0; i_data_i = '0; i_data_q = '0;
    idle(3);
    check("reset a outputs", {a_we, a_addr, a_din, a_ovf, a_err}, '0);
    check("reset b outputs", {b_we, b_addr, b_din, b_ovf, b_err}, '0);
    sys_rst = 1'b1;
    i_en    = 1'b1;

    // Frame counter wrap without a frame head (b has 4 symbols per frame).
    symbol(1'b1, 1'b0, 16'sd3, 16'sd4, 2);
    for (int s = 0; s < 3; s++) symbol(1'b0, 1'b1, 16'sd3, 16'sd4, 2);
    idle(5);
    check("wrap err before wrap", 64'(b_err), 64'd0);
    for (int s = 0; s < 2; s++) symbol(1'b0, 1'b1, 16'sd3, 16'sd4, 2);
    idle(5);
    check("wrap err b", 64'(b_err), 64'd1);
    check("wrap err a", 64'(a_err), 64'd0);
    for (int s = 0; s < 5; s++) begin
      check_wr($sformatf("wrap b%0d", s), 1'b1, (s == 4) ? 0 : s, 48'd50, c0);
      check_wr($sformatf("wrap a%0d", s), 1'b0, s, 48'd50, c0);
    end
    check_none("wrap");

    // Async reset in the middle of a symbol.
    symbol(1'b0, 1'b1, 16'sd3, 16'sd4, 6);
    #2 sys_rst = 1'b0;
    #1;
    check("midrst a outputs", {a_we, a_addr, a_din, a_ovf, a_err}, '0);
    check("midrst b outputs", {b_we, b_addr, b_din, b_ovf, b_err}, '0);
    check_wr("midrst prior b", 1'b1, 1, 48'd50, c0);
    check_wr("midrst prior a", 1'b0, 5, 48'd50, c0);
    idle(2);
    sys_rst = 1'b1;
    symbol(1'b0, 1'b0, 16'sd3, 16'sd4, 5);
    symbol(1'b0, 1'b1, 16'sd3, 16'sd4, 3);
    idle(6);
    check_none("midrst");

    // Three 8-sample symbols of I=1000: values, latency and pulse spacing.
    do_reset();
    symbol(1'b1, 1'b0, 16'sd1000, 16'sd0, 8);
    symbol(1'b0, 1'b1, 16'sd1000, 16'sd0, 8); h1 = head_edge;
    symbol(1'b0, 1'b1, 16'sd1000, 16'sd0, 8); h2 = head_edge;
    symbol(1'b1, 1'b0, 16'sd0, 16'sd0, 1);    h3 = head_edge;
    idle(6);
    check_wr("basic a0", 1'b0, 0, 48'd8000000, c0);
    check_wr("basic a1", 1'b0, 1, 48'd8000000, c1);
    check_wr("basic a2", 1'b0, 2, 48'd8000000, c2);
    check("basic latency", 64'(c0 - h1), 64'd3);
    check("basic spacing01", 64'(c1 - c0), 64'd8);
    check("basic spacing12", 64'(c2 - c1), 64'd8);
    check("basic close latency", 64'(c2 - h3), 64'd3);
    check("basic h2 latency", 64'(c1 - h2), 64'd3);
    for (int s = 0; s < 3; s++) check_wr($sformatf("basic b%0d", s), 1'b1, s, 48'd8000000, c0);
    check_none("basic");

    // Same frame with every other sample invalid and carrying junk.
    do_reset();
    symbol_sparse(1'b1, 1'b0, 16'sd1000, 16'sd0, 8);
    symbol_sparse(1'b0, 1'b1, 16'sd1000, 16'sd0, 8);
    symbol_sparse(1'b0, 1'b1, 16'sd1000, 16'sd0, 8);
    symbol(1'b1, 1'b0, 16'sd0, 16'sd0, 1);
    idle(6);
    for (int s = 0; s < 3; s++) check_wr($sformatf("sparse a%0d", s), 1'b0, s, 48'd8000000, c0);
    for (int s = 0; s < 3; s++) check_wr($sformatf("sparse b%0d", s), 1'b1, s, 48'd8000000, c0);
    check_none("sparse");

    // Table of single-symbol powers on the default instance.
    do_reset();
    for (int v = 0; v < 7; v++) symbol(v == 0, v != 0, tbl[v].di, tbl[v].dq, tbl[v].n);
    symbol(1'b1, 1'b0, 16'sd0, 16'sd0, 1);
    idle(6);
    for (int v = 0; v < 7; v++) check_wr($sformatf("tbl %0d", v), 1'b0, v, tbl[v].exp_din, c0);
    check("tbl ovf a", 64'(a_ovf), 64'd0);
    qb.delete();
    check_none("tbl");

    // Saturation: 512 full-scale samples reach 2^40 (saturates b, fits in a).
    do_reset();
    symbol(1'b1, 1'b0, -16'sd32768, -16'sd32768, 512);
    symbol(1'b1, 1'b0, 16'sd3, 16'sd4, 2);
    symbol(1'b1, 1'b0, 16'sd0, 16'sd0, 1);
    idle(6);
    check_wr("sat b", 1'b1, 0, 48'h00FF_FFFF_FFFF, c0);
    check_wr("sat a", 1'b0, 0, 48'h0100_0000_0000, c0);
    check_wr("sat next b", 1'b1, 0, 48'd50, c0);
    check_wr("sat next a", 1'b0, 0, 48'd50, c0);
    check("sat ovf b sticky", 64'(b_ovf), 64'd1);
    check("sat ovf a", 64'(a_ovf), 64'd0);
    check_none("sat");

    // Disable mid-symbol, re-enable, stray sym head in idle, then a clean frame.
    do_reset();
    symbol(1'b1, 1'b0, 16'sd100, 16'sd100, 5);
    @(negedge sys_clk);
    i_en = 1'b0;
    symbol(1'b0, 1'b0, 16'sd100, 16'sd100, 4);
    @(negedge sys_clk);
    i_en = 1'b1;
    symbol(1'b0, 1'b1, 16'sd30000, 16'sd30000, 4);
    symbol(1'b1, 1'b0, 16'sd3, 16'sd4, 2);
    symbol(1'b1, 1'b0, 16'sd0, 16'sd0, 1);
    idle(6);
    check_wr("en a", 1'b0, 0, 48'd50, c0);
    check_wr("en b", 1'b1, 0, 48'd50, c0);
    check_none("en");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
